// File: rtl/ifid_skid_reg.sv
// IF/ID boundary register: valid/ready handshake with a one-entry skid buffer,
// flush-to-bubble support and a saturating backpressure-cycle counter.
module ifid_skid_reg #(
  parameter int unsigned           DATA_W    = 32,
  parameter int unsigned           PC_W      = 32,
  parameter logic [DATA_W-1:0]     NOP_INSTR = 32'h0000_0013,
  parameter int unsigned           CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [PC_W-1:0]   out_pc,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt
);

  // StEmpty: main invalid; StFull: main valid; StSkid: main and skid valid.
  typedef enum logic [1:0] {StEmpty, StFull, StSkid} state_e;

  state_e            r_state, w_state_d;
  logic [DATA_W-1:0] r_main_instr, w_main_instr_d;
  logic [PC_W-1:0]   r_main_pc, w_main_pc_d;
  logic [DATA_W-1:0] r_skid_instr, w_skid_instr_d;
  logic [PC_W-1:0]   r_skid_pc, w_skid_pc_d;
  logic [CNT_W-1:0]  r_cnt, w_cnt_d;
  logic              w_stall;

  // Outputs come straight from state/registers; no path from out_ready to in_ready.
  assign in_ready  = (r_state != StSkid);
  assign out_valid = (r_state != StEmpty);
  assign out_instr = r_main_instr;
  assign out_pc    = r_main_pc;
  assign stall_cnt = r_cnt;

  assign w_stall = out_valid & ~out_ready;

  // Next-state and datapath selection; flush overrides every other transition.
  always_comb begin
    w_state_d      = r_state;
    w_main_instr_d = r_main_instr;
    w_main_pc_d    = r_main_pc;
    w_skid_instr_d = r_skid_instr;
    w_skid_pc_d    = r_skid_pc;
    if (flush) begin
      w_state_d      = StEmpty;
      w_main_instr_d = NOP_INSTR;
      w_main_pc_d    = '0;
      w_skid_instr_d = NOP_INSTR;
      w_skid_pc_d    = '0;
    end else begin
      unique case (r_state)
        StEmpty: begin
          if (in_valid) begin
            w_main_instr_d = in_instr;
            w_main_pc_d    = in_pc;
            w_state_d      = StFull;
          end
        end
        StFull: begin
          if (in_valid && out_ready) begin
            w_main_instr_d = in_instr;
            w_main_pc_d    = in_pc;
          end else if (in_valid && !out_ready) begin
            w_skid_instr_d = in_instr;
            w_skid_pc_d    = in_pc;
            w_state_d      = StSkid;
          end else if (!in_valid && out_ready) begin
            // Keep main at the bubble so out_* read NOP/0 while empty.
            w_main_instr_d = NOP_INSTR;
            w_main_pc_d    = '0;
            w_state_d      = StEmpty;
          end
        end
        StSkid: begin
          if (out_ready) begin
            w_main_instr_d = r_skid_instr;
            w_main_pc_d    = r_skid_pc;
            w_state_d      = StFull;
          end
        end
        default: w_state_d = StEmpty;
      endcase
    end
  end

  // Saturating stall counter; unaffected by flush.
  always_comb begin
    w_cnt_d = r_cnt;
    if (w_stall && (r_cnt != {CNT_W{1'b1}})) begin
      w_cnt_d = r_cnt + 1'b1;
    end
  end

  // State and storage registers with asynchronous reset to the bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StEmpty;
      r_main_instr <= NOP_INSTR;
      r_main_pc    <= '0;
      r_skid_instr <= NOP_INSTR;
      r_skid_pc    <= '0;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_state_d;
      r_main_instr <= w_main_instr_d;
      r_main_pc    <= w_main_pc_d;
      r_skid_instr <= w_skid_instr_d;
      r_skid_pc    <= w_skid_pc_d;
      r_cnt        <= w_cnt_d;
    end
  end

endmodule

// File: tb/tb_ifid_skid_reg.sv
// Directed bench for ifid_skid_reg: vector table plus saturation and reset sequences.
module tb_ifid_skid_reg;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready, flush;
  logic [31:0] in_instr, in_pc;
  logic        in_ready, out_valid;
  logic [31:0] out_instr, out_pc;
  logic [15:0] stall_cnt;
  logic        s_in_ready, s_out_valid;
  logic [31:0] s_out_instr, s_out_pc;
  logic [3:0]  s_stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ifid_skid_reg dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .flush     (flush),
    .stall_cnt (stall_cnt)
  );

  ifid_skid_reg #(.CNT_W(4)) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (s_in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .out_valid (s_out_valid),
    .out_ready (out_ready),
    .out_instr (s_out_instr),
    .out_pc    (s_out_pc),
    .flush     (flush),
    .stall_cnt (s_stall_cnt)
  );

  typedef struct {
    logic        iv;
    logic [31:0] ipc;
    logic        ordy;
    logic        fl;
    logic        eov;
    logic        eir;
    logic [31:0] epc;
    logic [15:0] ecnt;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] mk(input logic [31:0] pc);
    return 32'hC0DE_0000 | pc;
  endfunction

  function automatic vec_t v(input logic iv, input logic [31:0] ipc, input logic ordy,
                             input logic fl, input logic eov, input logic eir,
                             input logic [31:0] epc, input logic [15:0] ecnt);
    vec_t r;
    r.iv = iv; r.ipc = ipc; r.ordy = ordy; r.fl = fl;
    r.eov = eov; r.eir = eir; r.epc = epc; r.ecnt = ecnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] ipc, input logic ordy, input logic fl);
    in_valid  = iv;
    in_pc     = ipc;
    in_instr  = mk(ipc);
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic chk_outs(input string tag, input logic eov, input logic eir,
                          input logic [31:0] epc, input logic [15:0] ecnt);
    chk({tag, " out_valid"}, 64'(out_valid), 64'(eov));
    chk({tag, " in_ready"},  64'(in_ready),  64'(eir));
    chk({tag, " out_pc"},    64'(out_pc),    64'(epc));
    chk({tag, " out_instr"}, 64'(out_instr), 64'(eov ? mk(epc) : Nop));
    chk({tag, " stall_cnt"}, 64'(stall_cnt), 64'(ecnt));
  endtask

  initial begin
    logic [3:0] exp_sat;
    logic [15:0] exp_cnt;

    // Streaming
    tbl.push_back(v(1, 32'h00, 1, 0, 1, 1, 32'h00, 0));
    tbl.push_back(v(1, 32'h04, 1, 0, 1, 1, 32'h04, 0));
    tbl.push_back(v(1, 32'h08, 1, 0, 1, 1, 32'h08, 0));
    tbl.push_back(v(1, 32'h0C, 1, 0, 1, 1, 32'h0C, 0));
    // Backpressure: one extra accept into skid, then in_ready low
    tbl.push_back(v(1, 32'h10, 0, 0, 1, 0, 32'h0C, 1));
    tbl.push_back(v(1, 32'h14, 0, 0, 1, 0, 32'h0C, 2));
    tbl.push_back(v(1, 32'h14, 0, 0, 1, 0, 32'h0C, 3));
    // Release: skid drains first, 0x14 offered while not ready is ignored
    tbl.push_back(v(1, 32'h14, 1, 0, 1, 1, 32'h10, 3));
    tbl.push_back(v(1, 32'h14, 1, 0, 1, 1, 32'h14, 3));
    tbl.push_back(v(0, 32'h00, 1, 0, 0, 1, 32'h00, 3));
    // Flush in SKID with main=0x10, skid=0x14
    tbl.push_back(v(1, 32'h10, 0, 0, 1, 1, 32'h10, 3));
    tbl.push_back(v(1, 32'h14, 0, 0, 1, 0, 32'h10, 4));
    tbl.push_back(v(0, 32'h00, 0, 1, 0, 1, 32'h00, 5));
    tbl.push_back(v(0, 32'h00, 1, 0, 0, 1, 32'h00, 5));
    // Flush with simultaneous input transfer
    tbl.push_back(v(1, 32'h20, 1, 1, 0, 1, 32'h00, 5));
    tbl.push_back(v(0, 32'h00, 1, 0, 0, 1, 32'h00, 5));
    // Flush while FULL with concurrent in and out transfers
    tbl.push_back(v(1, 32'h24, 1, 0, 1, 1, 32'h24, 5));
    tbl.push_back(v(1, 32'h28, 1, 1, 0, 1, 32'h00, 5));
    tbl.push_back(v(0, 32'h00, 1, 0, 0, 1, 32'h00, 5));

    drive(0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk_outs("reset", 0, 1, 32'h0, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].iv, tbl[i].ipc, tbl[i].ordy, tbl[i].fl);
      @(posedge clk);
      #1;
      chk_outs($sformatf("v%0d", i), tbl[i].eov, tbl[i].eir, tbl[i].epc, tbl[i].ecnt);
      @(negedge clk);
    end

    // Saturation: one instruction held under backpressure for 20 cycles
    exp_cnt = 16'd5;
    exp_sat = 4'd5;
    drive(1, 32'h30, 0, 0);
    @(posedge clk);
    #1;
    chk("sat load out_pc", 64'(s_out_pc), 64'h30);
    @(negedge clk);
    drive(0, 0, 0, 0);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      exp_sat = (exp_sat == 4'hF) ? 4'hF : exp_sat + 4'd1;
      exp_cnt = exp_cnt + 16'd1;
      chk($sformatf("sat c%0d stall_cnt4", c), 64'(s_stall_cnt), 64'(exp_sat));
      @(negedge clk);
    end
    chk("sat final stall_cnt4", 64'(s_stall_cnt), 64'hF);
    chk_outs("sat main", 1, 1, 32'h30, exp_cnt);

    // Reset while in SKID
    drive(1, 32'h34, 0, 0);
    @(posedge clk);
    #1;
    chk("pre-rst in_ready", 64'(in_ready), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_outs("midrst", 0, 1, 32'h0, 0);
    chk("midrst stall_cnt4", 64'(s_stall_cnt), 64'h0);
    chk("midrst out_valid4", 64'(s_out_valid), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 32'h40, 1, 0);
    @(posedge clk);
    #1;
    chk_outs("post-rst", 1, 1, 32'h40, 0);
    @(negedge clk);
    drive(0, 0, 1, 0);
    @(posedge clk);
    #1;
    chk_outs("post-rst drain", 0, 1, 32'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ifid_skid_reg.md
# ifid_skid_reg

Parametrised IF/ID pipeline boundary register with a valid/ready handshake and a one-entry skid buffer. It sits between instruction fetch and decode. It carries the instruction and its PC, and decouples the two stages so that fetch can run at full throughput while decode applies backpressure. It also supports flush (bubble insertion) for taken branches and exceptions, and keeps a saturating backpressure-cycle counter for performance monitoring.

## Interface
- DATA_W, 32, instruction width in bits
- PC_W, 32, program counter width in bits
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0); width DATA_W
- CNT_W, 16, width of the stall statistics counter

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  fetch presents a valid instruction
- in_ready  output  1  block can accept this cycle; decoded from state, no combinational path from out_ready
- in_instr  input  DATA_W  fetched instruction
- in_pc  input  PC_W  PC of in_instr
- out_valid  output  1  decode-side instruction valid
- out_ready  input  1  decode accepts out_instr this cycle
- out_instr  output  DATA_W  instruction to decode; NOP_INSTR whenever out_valid=0
- out_pc  output  PC_W  PC of out_instr; 0 whenever out_valid=0
- flush  input  1  synchronous kill of all held and incoming instructions
- stall_cnt  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

## Operation
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Storage has two entries: main (drives the outputs) and skid (holds overflow).
- FSM has three states. EMPTY: main invalid. FULL: main valid. SKID: main and skid both valid.
- in_ready = (state != SKID). out_valid = (state != EMPTY).
- EMPTY:
  - in_valid: main <= in, go to FULL.
  - Otherwise, stay in EMPTY.
- FULL:
  - in_valid & out_ready: main <= in, stay in FULL.
  - in_valid & !out_ready: skid <= in, go to SKID.
  - !in_valid & out_ready: main <= {NOP_INSTR, 0}, go to EMPTY.
  - Otherwise, hold.
- SKID:
  - out_ready: main <= skid, go to FULL. The skid contents are don't-care afterwards.
  - Otherwise, hold both entries. in_valid is ignored because in_ready=0.
- flush has priority over everything else:
  - Next state is EMPTY, main <= {NOP_INSTR, 0}, skid cleared.
  - An input transfer in the same cycle is discarded.
  - An output transfer in the same cycle still counts as delivered to decode.
- stall_cnt:
  - Increments by 1 in every cycle where out_valid & !out_ready.
  - Holds at {CNT_W{1}} once saturated.
  - Not cleared by flush; cleared only by rst.
- Ordering: instructions leave in the order they were accepted. No duplication, and no loss except by flush.

## Timing
- Reset values (asynchronous, immediate):
  - state=EMPTY, out_valid=0, in_ready=1.
  - out_instr=NOP_INSTR, out_pc=0, stall_cnt=0.
- Release of rst is synchronous to clk. The first transfer in can occur on the first rising edge after deassertion.
- Latency: an instruction accepted at edge N is on out_* with out_valid=1 after edge N, i.e. in cycle N+1.
- Throughput: 1 instruction/cycle when out_ready is held high.
- Backpressure:
  - The first cycle of out_ready=0 while FULL still accepts one more instruction into skid.
  - in_ready falls in the following cycle.
  - in_ready rises one cycle after the out transfer that empties skid.
- Outputs out_*, in_ready and stall_cnt are register- or state-driven only. There is no combinational in→out path.
- rst asserted mid-operation: all held instructions are dropped and all outputs return to reset values immediately.
- flush while in SKID: both entries are dropped, and in_ready=1 in the next cycle.

## Test plan
- Streaming: with out_ready=1, drive PCs 0x0,0x4,0x8,0xC back-to-back. Required response: out_pc shows 0x0,0x4,0x8,0xC on consecutive cycles, each one cycle after its input, with in_ready held at 1.
- Backpressure/skid: streaming, then out_ready=0 for 3 cycles while in_valid=1. Required response:
  - in_ready drops after exactly one extra accept.
  - stall_cnt increments by 3.
  - On release, out_pc continues in order with no gap and no duplicate.
- Flush in SKID: with main=PC 0x10 and skid=PC 0x14, assert flush for one cycle. Required response: next cycle out_valid=0, out_instr=32'h00000013, out_pc=0, in_ready=1; PC 0x14 never appears on the output.
- Flush with simultaneous in transfer: in_valid=1 with PC 0x20 and flush=1 in the same cycle. Required response: out_valid=0 in the next cycle, and 0x20 never appears on the output.
- Saturation: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles. Required response: stall_cnt reaches 15 and stays at 15.
- Reset mid-stream: assert rst while in SKID. Required response: immediately out_valid=0, out_instr=NOP_INSTR, out_pc=0, stall_cnt=0, in_ready=1.
